// File: rtl/mips_memory_responder_pkg.sv
// Shared definitions for the mips memory responder:
// loader/run state encoding and the default I/O port address.
package mips_memory_responder_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

endpackage

// File: rtl/mips_memory_responder_if.sv
// Core byte bus, boot loader stream and I/O port of the memory responder.
// The responder is the slave; the core/loader/environment side is the master.
interface mips_memory_responder_if #(
    parameter int WIDTH = 8
);
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;

    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             cpu_rst;

    logic [WIDTH-1:0] io_in;
    logic [WIDTH-1:0] io_out;
    logic             io_strobe;

    modport master (
        output memread, memwrite, adr, writedata,
        output ld_valid, ld_data, ld_last,
        output io_in,
        input  memdata, ld_ready, cpu_rst, io_out, io_strobe
    );

    modport slave (
        input  memread, memwrite, adr, writedata,
        input  ld_valid, ld_data, ld_last,
        input  io_in,
        output memdata, ld_ready, cpu_rst, io_out, io_strobe
    );

endinterface

// File: rtl/mips_memory_responder_io_sync2.sv
// Two-flop synchronizer for the asynchronous external input byte.
// Both stages clear to zero on reset.
module io_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mips_memory_responder.sv
// Unified instruction/data RAM for the 8-bit multicycle mips core, with a
// boot loader that fills RAM while the core is held in reset, and one I/O byte.
module mips_memory_responder
    import mips_memory_responder_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] IO_ADDR = WIDTH'(IO_ADDR_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_memory_responder_if.slave     bus
);

    localparam int DEPTH = 2 ** WIDTH;

    state_t           state;
    logic [WIDTH-1:0] ld_addr;
    logic             cpu_rst_q;
    logic             ld_ready_q;
    logic [WIDTH-1:0] io_out_q;
    logic             io_strobe_q;
    logic [WIDTH-1:0] io_sync;
    logic [WIDTH-1:0] rd_data;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             ld_fire;
    logic             io_hit;
    logic             run_wr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_waddr;
    logic [WIDTH-1:0] ram_wdata;

    assign ld_fire = (state == LOAD) && bus.ld_valid;
    assign io_hit  = (bus.adr == IO_ADDR);
    assign run_wr  = (state == RUN) && bus.memwrite;

    // One RAM write port shared by the loader and the running core.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ld_addr;
        ram_wdata = bus.ld_data;
        if (ld_fire) begin
            ram_we = 1'b1;
        end else if (run_wr && !io_hit) begin
            ram_we    = 1'b1;
            ram_waddr = bus.adr;
            ram_wdata = bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            ld_addr     <= '0;
            cpu_rst_q   <= 1'b1;
            ld_ready_q  <= 1'b1;
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
        end else begin
            io_strobe_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.ld_valid) begin
                        ld_addr <= ld_addr + 1'b1;
                        // The loader stops short of the I/O address.
                        if (bus.ld_last || ld_addr == IO_ADDR - 1'b1) begin
                            state      <= RELEASE;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    state     <= RUN;
                    cpu_rst_q <= 1'b0;
                end
                RUN: begin
                    if (bus.memwrite && io_hit) begin
                        io_out_q    <= bus.writedata;
                        io_strobe_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= LOAD;
                    cpu_rst_q  <= 1'b1;
                    ld_ready_q <= 1'b1;
                end
            endcase
        end
    end

    io_sync2 #(
        .WIDTH (WIDTH)
    ) u_io_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (bus.io_in),
        .q   (io_sync)
    );

    // The core samples memdata in the cycle it raises memread.
    always_comb begin
        rd_data = '0;
        if (state == RUN && bus.memread) begin
            rd_data = io_hit ? io_sync : mem[bus.adr];
        end
    end

    assign bus.memdata   = rd_data;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.io_out    = io_out_q;
    assign bus.io_strobe = io_strobe_q;

endmodule

// File: tb/tb_mips_memory_responder.sv
// Directed bench for mips_memory_responder with a behavioural reference
// model compared every cycle, plus hand-computed literal checks.
module tb_mips_memory_responder;
    import mips_memory_responder_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mips_memory_responder_if #(.WIDTH(8)) bus ();

    mips_memory_responder #(
        .WIDTH   (8),
        .IO_ADDR (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model
    state_t     m_state = LOAD;
    int         m_addr  = 0;
    logic [7:0] mm [256];
    bit         mm_known [256];
    logic [7:0] m_io_out = 8'h00;
    bit         m_strobe = 1'b0;
    logic [7:0] s1 = 8'h00;
    logic [7:0] s2 = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state  = LOAD;
            m_addr   = 0;
            m_io_out = 8'h00;
            m_strobe = 1'b0;
            s1       = 8'h00;
            s2       = 8'h00;
        end else begin
            s2       = s1;
            s1       = bus.io_in;
            m_strobe = 1'b0;
            if (m_state == LOAD) begin
                if (bus.ld_valid) begin
                    mm[m_addr]       = bus.ld_data;
                    mm_known[m_addr] = 1'b1;
                    m_addr           = m_addr + 1;
                    if (bus.ld_last || m_addr == 255) m_state = RELEASE;
                end
            end else if (m_state == RELEASE) begin
                m_state = RUN;
            end else if (bus.memwrite) begin
                if (bus.adr == 8'hFF) begin
                    m_io_out = bus.writedata;
                    m_strobe = 1'b1;
                end else begin
                    mm[bus.adr]       = bus.writedata;
                    mm_known[bus.adr] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e_md;
        bit         md_ok;
        e_md  = 8'h00;
        md_ok = 1'b1;
        if (m_state == RUN && bus.memread) begin
            if (bus.adr == 8'hFF) begin
                e_md = s2;
            end else begin
                e_md  = mm[bus.adr];
                md_ok = mm_known[bus.adr];
            end
        end
        chk("model.ld_ready", {7'd0, bus.ld_ready},
            {7'd0, m_state == LOAD});
        chk("model.cpu_rst", {7'd0, bus.cpu_rst},
            {7'd0, m_state != RUN});
        chk("model.io_out", bus.io_out, m_io_out);
        chk("model.io_strobe", {7'd0, bus.io_strobe}, {7'd0, m_strobe});
        if (md_ok) chk("model.memdata", bus.memdata, e_md);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        cyc();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a,
                          input logic [7:0] exp);
        bus.memread = 1'b1;
        bus.adr     = a;
        #1;
        chk(name, bus.memdata, exp);
        cyc();
        bus.memread = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.adr       = 8'h00;
        bus.writedata = 8'h00;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h00;
        bus.ld_last   = 1'b0;
        bus.io_in     = 8'h00;
        repeat (2) cyc();
        chk("rst.cpu_rst", {7'd0, bus.cpu_rst}, 8'h01);
        chk("rst.ld_ready", {7'd0, bus.ld_ready}, 8'h01);
        chk("rst.io_out", bus.io_out, 8'h00);
        chk("rst.io_strobe", {7'd0, bus.io_strobe}, 8'h00);
        chk("rst.memdata", bus.memdata, 8'h00);
        rst = 1'b0;
        cyc();

        // Three-byte boot image
        load_byte(8'h20, 1'b0);
        load_byte(8'h05, 1'b0);
        load_byte(8'hA5, 1'b1);
        chk("load.ready_drop", {7'd0, bus.ld_ready}, 8'h00);
        chk("load.release_rst", {7'd0, bus.cpu_rst}, 8'h01);
        cyc();
        chk("load.run_rst", {7'd0, bus.cpu_rst}, 8'h00);
        rd_chk("load.mem0", 8'h00, 8'h20);
        rd_chk("load.mem1", 8'h01, 8'h05);
        rd_chk("load.mem2", 8'h02, 8'hA5);

        // RAM write/read in RUN
        bus.memwrite  = 1'b1;
        bus.adr       = 8'h40;
        bus.writedata = 8'h3C;
        cyc();
        bus.memwrite = 1'b0;
        rd_chk("run.rd40", 8'h40, 8'h3C);
        #1;
        chk("run.noread", bus.memdata, 8'h00);
        cyc();

        // Simultaneous read and write: old data, then new
        bus.memread   = 1'b1;
        bus.memwrite  = 1'b1;
        bus.adr       = 8'h40;
        bus.writedata = 8'h99;
        #1;
        chk("rw.old", bus.memdata, 8'h3C);
        cyc();
        bus.memwrite = 1'b0;
        #1;
        chk("rw.new", bus.memdata, 8'h99);
        cyc();
        bus.memread = 1'b0;

        // I/O port writes
        bus.memwrite  = 1'b1;
        bus.adr       = 8'hFF;
        bus.writedata = 8'h81;
        cyc();
        bus.memwrite = 1'b0;
        chk("io.out", bus.io_out, 8'h81);
        chk("io.strobe", {7'd0, bus.io_strobe}, 8'h01);
        cyc();
        chk("io.strobe_end", {7'd0, bus.io_strobe}, 8'h00);
        bus.memwrite  = 1'b1;
        bus.writedata = 8'h11;
        cyc();
        bus.writedata = 8'h22;
        chk("io.b2b_first", bus.io_out, 8'h11);
        cyc();
        bus.memwrite = 1'b0;
        chk("io.b2b_strobe", {7'd0, bus.io_strobe}, 8'h01);
        chk("io.b2b_second", bus.io_out, 8'h22);
        cyc();
        chk("io.b2b_end", {7'd0, bus.io_strobe}, 8'h00);

        // Input synchronizer latency
        bus.io_in   = 8'h5A;
        bus.memread = 1'b1;
        bus.adr     = 8'hFF;
        #1;
        chk("sync.edge0", bus.memdata, 8'h00);
        cyc();
        chk("sync.edge1", bus.memdata, 8'h00);
        cyc();
        chk("sync.edge2", bus.memdata, 8'h5A);
        bus.memread = 1'b0;

        // Async reset from RUN, then gapped loader stream
        rst = 1'b1;
        #1;
        chk("rst.async_cpu_rst", {7'd0, bus.cpu_rst}, 8'h01);
        cyc();
        rst = 1'b0;
        cyc();
        load_byte(8'h11, 1'b0);
        cyc();
        load_byte(8'h22, 1'b0);
        chk("gap.still_load", {7'd0, bus.ld_ready}, 8'h01);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        load_byte(8'h77, 1'b1);
        chk("reload.release", {7'd0, bus.cpu_rst}, 8'h01);
        cyc();
        chk("reload.run", {7'd0, bus.cpu_rst}, 8'h00);
        rd_chk("reload.mem0", 8'h00, 8'h77);
        rd_chk("reload.mem1", 8'h01, 8'h22);
        rd_chk("reload.mem2", 8'h02, 8'hA5);

        // Full-length stream without ld_last stops below IO_ADDR
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 255; i++) begin
            load_byte(8'(i) ^ 8'h5A, 1'b0);
        end
        chk("full.ready_drop", {7'd0, bus.ld_ready}, 8'h00);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hEE;
        cyc();
        bus.ld_valid = 1'b0;
        chk("full.run", {7'd0, bus.cpu_rst}, 8'h00);
        rd_chk("full.memFE", 8'hFE, 8'hA4);
        rd_chk("full.mem0", 8'h00, 8'h5A);
        rd_chk("full.mem40", 8'h40, 8'h1A);
        rd_chk("full.io_read", 8'hFF, 8'h5A);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_memory_responder.md
Name: mips_memory_responder

Overview:
Memory-side responder for the 8-bit multicycle mips core's byte bus (memread, memwrite, adr, writedata, memdata). It holds a 2^WIDTH x WIDTH unified instruction/data RAM and answers core reads and writes. A boot loader fills the RAM from a valid/ready byte stream while the core is held in reset. The block also maps one byte-wide I/O register at IO_ADDR.

Parameters:
WIDTH, 8, data and address width; RAM has 2^WIDTH locations
IO_ADDR, 8'hFF, address decoded as the I/O port; the RAM location at this address is never used

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
memread  input  1  core read request
memwrite  input  1  core write request
adr  input  WIDTH  core byte address
writedata  input  WIDTH  core write data
memdata  output  WIDTH  read data to core
ld_valid  input  1  loader byte valid
ld_data  input  WIDTH  loader byte
ld_last  input  1  marks the final loader byte; qualified by ld_valid
ld_ready  output  1  loader may present a byte
cpu_rst  output  1  reset to the core's rst input
io_in  input  WIDTH  external input byte, asynchronous to clk
io_out  output  WIDTH  registered output port
io_strobe  output  1  one-cycle pulse when io_out is written

Behaviour:
- Reset (async, rst=1): state=LOAD, ld_addr=0, cpu_rst=1, ld_ready=1, io_out=0, io_strobe=0, both io sync flops=0. RAM contents are not cleared.
- States and transitions:
  - LOAD: ld_ready=1 and cpu_rst=1.
    - Handshake: when ld_valid=1 on an edge, mem[ld_addr]<=ld_data and ld_addr<=ld_addr+1.
    - Exit: an accepted byte with ld_last=1, or an accepted byte at ld_addr==IO_ADDR-1, moves LOAD->RELEASE. The loader never writes IO_ADDR and ld_addr never wraps.
  - RELEASE: exactly one cycle. ld_ready=0 and cpu_rst=1. Moves to RUN.
  - RUN: ld_ready=0 and cpu_rst=0. ld_valid is ignored. The state is terminal until rst.
- cpu_rst is a registered output. It is forced to 1 asynchronously by rst and deasserts at the edge that enters RUN.
- Core bus in LOAD and RELEASE: memread and memwrite are ignored, and memdata=0.
- Core bus in RUN, reads:
  - Reads are combinational with zero latency. With memread=1, memdata = mem[adr] if adr!=IO_ADDR, else io_sync (second synchronizer stage).
  - With memread=0, memdata=0.
  - The core latches memdata in the same cycle it asserts memread, so this path must stay combinational.
- Core bus in RUN, writes:
  - Writes are synchronous. When memwrite=1 and adr!=IO_ADDR, mem[adr]<=writedata on the edge.
  - When memwrite=1 and adr==IO_ADDR, io_out<=writedata and io_strobe=1 for the following cycle only.
  - Back-to-back I/O writes hold io_strobe high for each cycle written.
- memread and memwrite together at the same adr: the write happens at the edge, and memdata shows the old content for that cycle.
- io_in is synchronized by two flops before it can be read. A change on io_in is visible no earlier than the second edge after it.
- Reset mid-load or mid-run returns to LOAD with ld_addr=0 and cpu_rst=1. Previously loaded bytes stay in RAM until overwritten.
- Address arithmetic is WIDTH-bit unsigned. There is no width mismatch: adr indexes the full RAM.

Decomposition:
- Shared package holds the state encoding (LOAD=2'd0, RELEASE=2'd1, RUN=2'd2) and the default IO_ADDR constant, so the bench and the top level share them.
- One sub-module, io_sync2: a WIDTH-wide two-flop synchronizer with async reset to 0.
- RAM, loader FSM and I/O decode stay in the top module.

Test Plan:
- Reset, then stream bytes 8'h20,8'h05,8'hA5 with ld_last on the third -> mem[0..2]=20,05,A5; ld_ready drops after the third accept; cpu_rst=1 for one more cycle, then 0.
- ld_valid toggling 1,0,1 during LOAD -> only the two valid-qualified bytes are written, to addresses 0 and 1; ld_addr does not advance on idle cycles.
- Stream 255 bytes without ld_last -> load terminates after address 8'hFE; mem[8'hFF] is untouched; state reaches RUN.
- In RUN: memwrite adr=8'h40 data=8'h3C, then memread adr=8'h40 -> memdata=3C. Then memread=0 -> memdata=0.
- In RUN: memwrite adr=8'hFF data=8'h81 -> io_out=81 and a single-cycle io_strobe. Set io_in=8'h5A and read 8'hFF -> 5A returned from the second edge on, with the old value before that.
- Assert rst mid-load after 2 bytes, then reload 1 byte 8'h77 with ld_last -> mem[0]=77, mem[1] keeps its earlier value, cpu_rst asserts immediately on rst and releases after the RELEASE cycle.
